// File: rtl/audio_delay_echo.sv
// audio_delay_echo: stereo sample pump with passthrough/mute/delay/feedback-echo modes over a circular delay line.
module audio_delay_echo #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 12,
  parameter int ECHO_SHIFT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              primed
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              primed_q;
  logic [DATA_W-1:0] in_l_q, in_r_q, wd_l_q, wd_r_q, rd_l_q, rd_r_q;
  logic [DATA_W-1:0] mem_l [2**ADDR_W];
  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [DATA_W-1:0] d_l, d_r, out_l, out_r, st_l, st_r;
  // Returns {output sample, value to store back into the delay line}.
  function automatic logic [2*DATA_W-1:0] lane(input logic [1:0] m, input logic [DATA_W-1:0] x, d);
    logic [DATA_W-1:0] ds;
    logic [DATA_W:0]   s;
    logic [DATA_W-1:0] e;
    ds = $signed(d) >>> ECHO_SHIFT;
    s  = {x[DATA_W-1], x} + {ds[DATA_W-1], ds};
    e  = (s[DATA_W] != s[DATA_W-1]) ? {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}} : s[DATA_W-1:0];
    return m == 2'b00 ? {x, x} : m == 2'b01 ? {{DATA_W{1'b0}}, x} : m == 2'b10 ? {d, x} : {e, e};
  endfunction
  assign d_l = primed_q ? rd_l_q : '0;
  assign d_r = primed_q ? rd_r_q : '0;
  assign {out_l, st_l} = lane(mode, in_l_q, d_l);
  assign {out_r, st_r} = lane(mode, in_r_q, d_r);
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;
  assign primed          = primed_q;
  always_comb begin
    read    = reset && state_q == IDLE && read_ready && write_ready;
    write   = state_q == SEND && write_ready;
    state_d = state_q == IDLE ? (read ? FETCH : IDLE) :
              state_q == FETCH ? SEND : (write ? IDLE : SEND);
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      primed_q <= 1'b0;
      in_l_q   <= '0;
      in_r_q   <= '0;
      wd_l_q   <= '0;
      wd_r_q   <= '0;
    end else begin
      state_q <= state_d;
      if (read) begin
        in_l_q <= readdata_left;
        in_r_q <= readdata_right;
      end
      if (state_q == FETCH) begin
        wd_l_q <= out_l;
        wd_r_q <= out_r;
      end
      if (write) begin
        ptr_q <= ptr_q + 1'b1;
        if (&ptr_q) primed_q <= 1'b1;
      end
    end
  end
  // Plain RAM: never reset, stale contents are hidden by primed_q.
  always_ff @(posedge CLOCK_50) begin
    rd_l_q <= mem_l[ptr_q];
    rd_r_q <= mem_r[ptr_q];
    if (state_q == FETCH) begin
      mem_l[ptr_q] <= st_l;
      mem_r[ptr_q] <= st_r;
    end
  end
endmodule

// File: tb/tb_audio_delay_echo.sv
// tb_audio_delay_echo: directed literal checks plus randomized traffic against a transfer-level reference model.
module tb_audio_delay_echo;
  localparam int DW = 24, AW = 2, ES = 1, DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic [1:0] mode = 0;
  logic read_ready = 0, write_ready = 0;
  logic [DW-1:0] readdata_left = 0, readdata_right = 0;
  logic read, write, primed;
  logic [DW-1:0] writedata_left, writedata_right;
  int checks = 0, errors = 0, cyc = 0, lat = 0, n = 0, dl = 0, dr = 0, nreads = 0;
  logic [DW-1:0] hl[$], hr[$];
  logic [DW-1:0] il, ir, el, er, sl, sr, ol, orr, hold_l;
  bit got = 0, pend = 0;

  audio_delay_echo #(.DATA_W(DW), .ADDR_W(AW), .ECHO_SHIFT(ES)) dut (
    .CLOCK_50(clk), .reset(rst_n), .mode(mode), .read_ready(read_ready), .write_ready(write_ready),
    .readdata_left(readdata_left), .readdata_right(readdata_right), .read(read), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right), .primed(primed));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [47:0] a, logic [47:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endfunction

  function automatic int sx(logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [DW-1:0] sat(int v);
    return v > 8388607 ? 24'h7FFFFF : v < -8388608 ? 24'h800000 : v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] pick();
    int k = $urandom_range(0, 5);
    return k == 0 ? 24'h7FFFFF : k == 1 ? 24'h800000 : k == 2 ? 24'h7FFFFE : DW'($urandom);
  endfunction

  // Transfer-level model: transfer n sees what was stored at transfer n-DEPTH once primed.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_read", read, 0);
      chk("rst_write", write, 0);
      chk("rst_wd", {writedata_left, writedata_right}, 0);
      chk("rst_primed", primed, 0);
      hl.delete(); hr.delete();
      n = 0; got = 0; pend = 0;
    end else begin
      chk("rw_excl", read && write, 0);
      chk("primed", primed, n >= DEPTH);
      if (write) begin
        chk("write_pending", pend, 1);
        chk("write_rdy", write_ready, 1);
        chk("out_l", writedata_left, el);
        chk("out_r", writedata_right, er);
        n++;
        pend = 0;
      end else if (pend) begin
        chk("hold_l", writedata_left, el);
        chk("hold_r", writedata_right, er);
      end
      if (got) begin
        dl = n >= DEPTH ? sx(hl[n-DEPTH]) : 0;
        dr = n >= DEPTH ? sx(hr[n-DEPTH]) : 0;
        case (mode)
          2'b00: begin el = il; er = ir; sl = il; sr = ir; end
          2'b01: begin el = 0; er = 0; sl = il; sr = ir; end
          2'b10: begin el = dl[DW-1:0]; er = dr[DW-1:0]; sl = il; sr = ir; end
          default: begin
            el = sat(sx(il) + (dl >>> ES)); er = sat(sx(ir) + (dr >>> ES)); sl = el; sr = er;
          end
        endcase
        hl.push_back(sl); hr.push_back(sr);
        got = 0; pend = 1;
      end
      if (read) begin
        chk("read_rdy", read_ready && write_ready, 1);
        chk("read_busy", got || pend, 0);
        il = readdata_left; ir = readdata_right; got = 1;
      end
    end
  end

  task automatic xfer(input logic [1:0] m, input logic [DW-1:0] l, r, output logic [DW-1:0] xl, xr);
    int k, rc;
    mode = m; readdata_left = l; readdata_right = r; read_ready = 1; write_ready = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!read && k < 20);
    chk("read_seen", read, 1);
    rc = cyc;
    @(posedge clk); #1 read_ready = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!write && k < 20);
    chk("write_seen", write, 1);
    lat = cyc - rc; xl = writedata_left; xr = writedata_right;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask

  initial begin
    read_ready = 1; write_ready = 1;
    repeat (3) @(posedge clk);
    #1 write_ready = 0; rst_n = 1;
    repeat (4) begin @(negedge clk); chk("idle_no_read", read, 0); end
    @(posedge clk); #1;
    // passthrough, latency and throughput
    xfer(2'b00, 24'h123456, 24'hFEDCBA, ol, orr);
    chk("pt_l", ol, 24'h123456);
    chk("pt_r", orr, 24'hFEDCBA);
    chk("pt_latency", lat, 2);
    read_ready = 1; write_ready = 1; nreads = 0;
    repeat (9) begin @(negedge clk); nreads += int'(read); end
    @(posedge clk); #1 read_ready = 0;
    chk("pt_period", nreads, 3);
    // pure delay through a 4-deep line
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      xfer(2'b10, DW'(i), DW'(10 + i), ol, orr);
      chk("dly_l", ol, i > 4 ? i - 4 : 0);
      chk("dly_r", orr, i > 4 ? 6 + i : 0);
      if (i == 3 || i == 4) chk("dly_primed", primed, i == 4);
    end
    // echo saturation at both rails
    do_reset();
    repeat (4) xfer(2'b00, 24'h7FFFFE, 24'h800000, ol, orr);
    xfer(2'b11, 24'h7FFFFE, 24'h800000, ol, orr);
    chk("echo_pos_sat", ol, 24'h7FFFFF);
    chk("echo_neg_sat", orr, 24'h800000);
    // output stall
    mode = 2'b00; readdata_left = 24'h0ABCDE; readdata_right = 24'h054321;
    read_ready = 1; write_ready = 1;
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!read && k < 20);
      chk("stall_read_seen", read, 1);
    end
    @(posedge clk); #1 read_ready = 0; write_ready = 0;
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_write", write, 0);
      chk("stall_read", read, 0);
      chk("stall_wd", writedata_left, 24'h0ABCDE);
      @(posedge clk); #1;
    end
    write_ready = 1;
    @(negedge clk); chk("stall_release", write, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("stall_single", write, 0);
    @(posedge clk); #1;
    // reset while a sample sits in FETCH
    mode = 2'b10; readdata_left = 24'h111111; readdata_right = 24'h222222; read_ready = 1; write_ready = 1;
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!read && k < 20);
      chk("mr_read_seen", read, 1);
    end
    @(posedge clk); #1 read_ready = 0; rst_n = 0;
    #1;
    chk("mr_out", {read, write, primed}, 0);
    chk("mr_wd", {writedata_left, writedata_right}, 0);
    @(posedge clk); #1 rst_n = 1;
    xfer(2'b10, 24'h000055, 24'h000066, ol, orr);
    chk("mr_masked", {ol, orr}, 0);
    // randomized traffic
    for (int i = 0; i < 2400; i++) begin
      read_ready = $urandom_range(0, 3) != 0;
      write_ready = $urandom_range(0, 3) != 0;
      readdata_left = pick(); readdata_right = pick();
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      @(posedge clk); #1;
    end
    read_ready = 0; write_ready = 1;
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_delay_echo.md
# audio_delay_echo

Stereo audio stream processor between the CODEC read FIFO and CODEC write FIFO: consumes one left/right sample pair per transfer, applies a selectable mode (passthrough, mute, pure delay, feedback echo) using a per-channel circular delay line, and emits the result to the CODEC. Successor to the plain mic-to-speaker passthrough. It adds a sequenced read/write handshake, an on-chip delay memory, saturating arithmetic and runtime mode selection.

## Interface
- DATA_W, 24, sample width, signed two's complement
- ADDR_W, 12, delay-line address width; depth DEPTH = 2**ADDR_W samples per channel
- ECHO_SHIFT, 1, arithmetic right shift applied to the delayed sample in echo mode (gain 2^-ECHO_SHIFT)

- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- mode  in  2  00 passthrough, 01 mute, 10 delay, 11 echo; sampled in FETCH
- read_ready  in  1  CODEC input FIFO holds a sample pair
- write_ready  in  1  CODEC output FIFO has space
- readdata_left, readdata_right  in  DATA_W  input samples, valid while read_ready
- read  out  1  pop strobe to CODEC input FIFO
- write  out  1  push strobe to CODEC output FIFO
- writedata_left, writedata_right  out  DATA_W  registered output samples
- primed  out  1  delay line has been filled once since reset

## Operation
- FSM states: IDLE, FETCH, SEND.
- IDLE: read = read_ready & write_ready (combinational, this state only). When 1, capture readdata_left/right into in_l/in_r and go to FETCH. Otherwise stay.
- Delay memory: one DEPTH x DATA_W synchronous-read RAM per channel. Read address = wr_ptr at all times, and data appears one cycle later. In FETCH, d_l/d_r = RAM output if primed, else 0.
- FETCH: compute out per channel and register it into writedata, then write RAM[wr_ptr] with the store value. Go to SEND.
  - 00 passthrough: out = in, store = in
  - 01 mute: out = 0, store = in
  - 10 delay: out = d, store = in
  - 11 echo: out = sat(in + (d >>> ECHO_SHIFT)), store = out (feedback)
- Echo saturation: signed add in DATA_W+1 bits, then clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] (24-bit: 0x800000..0x7FFFFF).
- SEND: write = write_ready (this state only). On write=1: wr_ptr <= wr_ptr+1 mod DEPTH, go to IDLE. If write_ready is 0, hold in SEND with writedata stable.
- primed: set when wr_ptr wraps from DEPTH-1 to 0 on a SEND transfer. Stays set until reset.
- Delay in transfers: with primed=1, the delay/echo tap returns the value stored exactly DEPTH transfers earlier.
- read and write are never asserted in the same cycle.
- Async reset (any state, mid-transfer included): state = IDLE, wr_ptr = 0, primed = 0, writedata_* = 0, in_* = 0, read = write = 0. RAM contents are not cleared and are masked by primed = 0. An in-flight sample is discarded.

## Timing
- Minimum 3 cycles per sample pair: IDLE (read), FETCH, SEND (write). Back-to-back throughput is 1 pair per 3 cycles.
- read is a one-cycle pulse per transfer. Data is captured at the same edge as the pop.
- writedata updates at the end of FETCH and is valid for the whole SEND state, including any stall.
- Output reset values: read 0, write 0, writedata_left/right 0, primed 0.
- mode changes take effect on the next FETCH. A sample already in SEND keeps its computed value.
- RAM write in FETCH and RAM read of the same address are never the same cycle: the read happens in IDLE→FETCH, the write lands at the FETCH edge.

## Test plan
- Reset/idle: hold reset=0 with read_ready=1 → read=write=0, writedata=0, primed=0. Release with write_ready=0 → read stays 0.
- Passthrough: mode=00, L=0x123456, R=0xFEDCBA, both readies 1 → read pulse, write pulse exactly 2 cycles later, writedata=0x123456/0xFEDCBA. Steady-state period is 3 cycles.
- Delay (ADDR_W=2): mode=10, inputs 1,2,3,4,5,6 → outputs 0,0,0,0,1,2. primed rises after the 4th write.
- Echo saturation (ADDR_W=2, ECHO_SHIFT=1): mode=11, primed, stored 0x7FFFFE, input 0x7FFFFE → output 0x7FFFFF. Stored 0x800000 with input 0x800000 → 0x800000.
- Write stall: in SEND, drop write_ready for 5 cycles → write=0, writedata stable, wr_ptr unchanged, no read. Restore → single write, then IDLE.
- Mid-transfer reset: assert reset in FETCH → all outputs 0 immediately. After release, the first output in mode 10 is 0 (primed masked).
